alarm_clock_ctrl: RTL and testbench
===================================

Name: alarm_clock_ctrl

Overview:
Consumes the one-clock button pulses from the push-button edge-detect stage and implements the alarm clock core. It keeps time of day, lets the user set the time and the alarm through a mode/increment state machine, and drives the alarm ring output. It sits directly downstream of the button edge detectors and upstream of the display and buzzer drivers.

Parameters:
TICKS_PER_SEC, 50000000, clk cycles per second; set to 4 for simulation.
RING_SECS, 60, seconds the alarm rings before auto-clearing.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
mode_pls  input  1  one-cycle pulse; advances the mode FSM
inc_pls  input  1  one-cycle pulse; increments the field being edited
stop_pls  input  1  one-cycle pulse; silences a ringing alarm
alm_en  input  1  level; alarm armed when 1
hours  output  5  current hour, 0-23
minutes  output  6  current minute, 0-59
seconds  output  6  current second, 0-59
alarm_hr  output  5  alarm hour, 0-23
alarm_min  output  6  alarm minute, 0-59
mode  output  3  FSM state encoding
ring  output  1  alarm sounding

Behaviour:
- Clocking and reset: one clock, clk. rst_n is asynchronous and active-low. All outputs are registered.
- Reset values:
  - hours=0, minutes=0, seconds=0
  - alarm_hr=7, alarm_min=0
  - mode=RUN, ring=0, tick counter=0, ring counter=0
- Reset asserted mid-operation returns every output to these values immediately.
- Tick counter:
  - Counts 0..TICKS_PER_SEC-1.
  - sec_tick is asserted in the cycle the counter equals TICKS_PER_SEC-1; the counter then wraps to 0.
  - The counter is held at 0 in SET_HR and SET_MIN.
- FSM states: RUN=0, SET_HR=1, SET_MIN=2, ALM_HR=3, ALM_MIN=4. Encodings 5-7 are unreachable and recover to RUN on the next clock.
- mode_pls transitions: RUN->SET_HR->SET_MIN->ALM_HR->ALM_MIN->RUN.
- Leaving SET_MIN clears seconds to 0.
- mode_pls and inc_pls in the same cycle: mode wins and inc is ignored.
- Timekeeping runs in RUN, ALM_HR and ALM_MIN; it is frozen in SET_HR and SET_MIN.
- On sec_tick:
  - seconds increments; 59 wraps to 0 and carries to minutes.
  - minutes 59 wraps to 0 and carries to hours.
  - hours 23 wraps to 0.
  - 23:59:59 becomes 00:00:00.
- inc_pls, by state:
  - SET_HR: hours+1, 23 wraps to 0.
  - SET_MIN: minutes+1, 59 wraps to 0, no carry into hours.
  - ALM_HR / ALM_MIN: same rules applied to alarm_hr / alarm_min.
  - RUN: no effect.
- Latency: each inc_pls or mode_pls is visible on the outputs one clock after the pulse.
- Alarm trigger:
  - ring sets on the clock following a sec_tick whose update produces hours==alarm_hr, minutes==alarm_min, seconds==0, while alm_en=1.
  - Setting the time by hand onto the alarm time never triggers ring.
- Alarm clear: ring clears on stop_pls, on alm_en=0, or after RING_SECS sec_ticks counted from set.
- A clear condition in the same cycle as a trigger: clear wins and ring stays 0.
- ring is independent of mode; entering a SET state does not clear it.
- Widths: all counters are unsigned binary. Out-of-range values are never produced.

Test Plan:
1. TICKS_PER_SEC=4, reset released -> 00:00:00, alarm 07:00, mode=0, ring=0. After 4*60 clocks -> 00:01:00.
2. Force time to 23:59:59 via SET plus ticks, then one sec_tick -> 00:00:00, no glitch on the hours/minutes outputs.
3. mode_pls x1, inc_pls x25 -> hours=1 (wraps at 24). mode_pls -> SET_MIN, inc_pls x61 -> minutes=1, hours still 1. mode_pls -> seconds=0, mode=3.
4. Set the alarm to 00:02 with alm_en=1, return to RUN at 00:01:00 -> ring=1 one clock after the tick reaching 00:02:00. It auto-clears after 60 ticks with RING_SECS=60.
5. Ring active, stop_pls -> ring=0 the next clock. Repeat the trigger with stop_pls coincident with the trigger tick -> ring never asserts. Repeat with alm_en=0 -> ring never asserts.
6. mode_pls and inc_pls in the same cycle in SET_HR -> state advances to SET_MIN with hours unchanged. Assert rst_n=0 mid-SET_MIN -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/alarm_clock_ctrl.sv
// Alarm clock core: time of day, mode/increment setting FSM and alarm ring control.
// Consumes one-cycle button pulses; all outputs are registered.
module alarm_clock_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned RING_SECS     = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_pls,
  input  logic       inc_pls,
  input  logic       stop_pls,
  input  logic       alm_en,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [4:0] alarm_hr,
  output logic [5:0] alarm_min,
  output logic [2:0] mode,
  output logic       ring
);

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    SET_HR  = 3'd1,
    SET_MIN = 3'd2,
    ALM_HR  = 3'd3,
    ALM_MIN = 3'd4
  } state_t;

  localparam int unsigned TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned RW = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_SEC - 1);
  localparam logic [RW-1:0] RING_MAX = RW'(RING_SECS - 1);

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic [RW-1:0] ring_cnt;

  logic       running;
  logic       sec_tick;
  logic [4:0] hr_nxt;
  logic [5:0] min_nxt;
  logic [5:0] sec_nxt;
  logic       ring_trig;
  logic       ring_clear;

  assign mode = state;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    running  = (state == RUN) || (state == ALM_HR) || (state == ALM_MIN);
    sec_tick = running && (tick_cnt == TICK_MAX);
    hr_nxt   = hours;
    min_nxt  = minutes;
    sec_nxt  = seconds;
    if (sec_tick) begin
      if (seconds == 6'd59) begin
        sec_nxt = 6'd0;
        if (minutes == 6'd59) begin
          min_nxt = 6'd0;
          hr_nxt  = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
        end else begin
          min_nxt = minutes + 6'd1;
        end
      end else begin
        sec_nxt = seconds + 6'd1;
      end
    end
    // Only a running-clock rollover onto the alarm time triggers; manual setting never does.
    ring_trig  = sec_tick && alm_en && (sec_nxt == 6'd0) &&
                 (hr_nxt == alarm_hr) && (min_nxt == alarm_min);
    ring_clear = stop_pls || !alm_en || (ring && sec_tick && (ring_cnt == RING_MAX));
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (!running || (tick_cnt == TICK_MAX)) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      hours     <= 5'd0;
      minutes   <= 6'd0;
      seconds   <= 6'd0;
      alarm_hr  <= 5'd7;
      alarm_min <= 6'd0;
    end else begin
      hours   <= hr_nxt;
      minutes <= min_nxt;
      seconds <= sec_nxt;
      // mode_pls takes priority over inc_pls in every state.
      case (state)
        RUN: begin
          if (mode_pls) state <= SET_HR;
        end
        SET_HR: begin
          if (mode_pls)     state <= SET_MIN;
          else if (inc_pls) hours <= (hours == 5'd23) ? 5'd0 : hours + 5'd1;
        end
        SET_MIN: begin
          if (mode_pls) begin
            state   <= ALM_HR;
            seconds <= 6'd0;
          end else if (inc_pls) begin
            minutes <= (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
          end
        end
        ALM_HR: begin
          if (mode_pls)     state    <= ALM_MIN;
          else if (inc_pls) alarm_hr <= (alarm_hr == 5'd23) ? 5'd0 : alarm_hr + 5'd1;
        end
        ALM_MIN: begin
          if (mode_pls)     state     <= RUN;
          else if (inc_pls) alarm_min <= (alarm_min == 6'd59) ? 6'd0 : alarm_min + 6'd1;
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ring     <= 1'b0;
      ring_cnt <= '0;
    end else if (ring_clear) begin
      ring     <= 1'b0;
      ring_cnt <= '0;
    end else if (ring_trig) begin
      ring     <= 1'b1;
      ring_cnt <= '0;
    end else if (ring && sec_tick) begin
      ring_cnt <= ring_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Directed bench for alarm_clock_ctrl with TICKS_PER_SEC=4, RING_SECS=60.
// Inputs change and outputs are sampled on the falling edge.
module tb_alarm_clock_ctrl;

  logic       clk;
  logic       rst_n;
  logic       mode_pls;
  logic       inc_pls;
  logic       stop_pls;
  logic       alm_en;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [4:0] alarm_hr;
  logic [5:0] alarm_min;
  logic [2:0] mode;
  logic       ring;

  int n_cmp = 0;
  int n_bad = 0;

  alarm_clock_ctrl #(.TICKS_PER_SEC(4), .RING_SECS(60)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode_pls  (mode_pls),
    .inc_pls   (inc_pls),
    .stop_pls  (stop_pls),
    .alm_en    (alm_en),
    .hours     (hours),
    .minutes   (minutes),
    .seconds   (seconds),
    .alarm_hr  (alarm_hr),
    .alarm_min (alarm_min),
    .mode      (mode),
    .ring      (ring)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    mode_pls = 1'b0;
    inc_pls  = 1'b0;
    stop_pls = 1'b0;
    alm_en   = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_mode(input int n);
    repeat (n) begin
      mode_pls = 1'b1;
      @(negedge clk);
    end
    mode_pls = 1'b0;
  endtask

  task automatic pulse_inc(input int n);
    repeat (n) begin
      inc_pls = 1'b1;
      @(negedge clk);
    end
    inc_pls = 1'b0;
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, ".hours"}, int'(hours), h);
    check({tag, ".minutes"}, int'(minutes), m);
    check({tag, ".seconds"}, int'(seconds), s);
  endtask

  task automatic check_reset_state(input string tag);
    check_time(tag, 0, 0, 0);
    check({tag, ".alarm_hr"}, int'(alarm_hr), 7);
    check({tag, ".alarm_min"}, int'(alarm_min), 0);
    check({tag, ".mode"}, int'(mode), 0);
    check({tag, ".ring"}, int'(ring), 0);
  endtask

  // From RUN: walk to ALM_HR, add a_hr to alarm hours, a_min to alarm minutes, back to RUN.
  task automatic set_alarm(input int a_hr, input int a_min);
    pulse_mode(3);
    pulse_inc(a_hr);
    pulse_mode(1);
    pulse_inc(a_min);
    pulse_mode(1);
  endtask

  // From RUN: add h to hours and m to minutes, clear seconds, back to RUN.
  // The tick counter restarts at the SET_MIN exit, so the first tick lands 2 clocks after return.
  task automatic set_time(input int h, input int m);
    pulse_mode(1);
    pulse_inc(h);
    pulse_mode(1);
    pulse_inc(m);
    pulse_mode(3);
  endtask

  // Alarm 00:02, time 00:01:00; ring expected 238 clocks after return.
  task automatic setup_alarm_0002();
    do_reset();
    set_alarm(17, 2);
    set_time(0, 1);
    alm_en = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    mode_pls = 1'b0;
    inc_pls  = 1'b0;
    stop_pls = 1'b0;
    alm_en   = 1'b0;

    // 1: reset values, then one minute of free running
    do_reset();
    check_reset_state("t1_reset");
    wait_clk(3);
    check("t1_before_tick.seconds", int'(seconds), 0);
    wait_clk(1);
    check("t1_first_tick.seconds", int'(seconds), 1);
    wait_clk(236);
    check_time("t1_one_min", 0, 1, 0);

    // 3: hour wrap at 24, minute wrap without carry, seconds cleared leaving SET_MIN
    do_reset();
    wait_clk(12);
    check("t3_run.seconds", int'(seconds), 3);
    pulse_mode(1);
    check("t3_set_hr.mode", int'(mode), 1);
    pulse_inc(25);
    check("t3_hr_wrap.hours", int'(hours), 1);
    check("t3_frozen.seconds", int'(seconds), 3);
    pulse_mode(1);
    check("t3_set_min.mode", int'(mode), 2);
    pulse_inc(61);
    check("t3_min_wrap.minutes", int'(minutes), 1);
    check("t3_no_carry.hours", int'(hours), 1);
    pulse_mode(1);
    check("t3_alm_hr.mode", int'(mode), 3);
    check("t3_sec_clear.seconds", int'(seconds), 0);

    // 2: 23:59:59 rolls to 00:00:00
    do_reset();
    set_time(23, 59);
    wait_clk(237);
    check_time("t2_pre_wrap", 23, 59, 59);
    wait_clk(1);
    check_time("t2_wrap", 0, 0, 0);

    // 4: alarm trigger and auto-clear after 60 ticks
    setup_alarm_0002();
    check("t4_alarm.alarm_hr", int'(alarm_hr), 0);
    check("t4_alarm.alarm_min", int'(alarm_min), 2);
    check("t4_run.mode", int'(mode), 0);
    wait_clk(237);
    check_time("t4_pre_trig", 0, 1, 59);
    check("t4_pre_trig.ring", int'(ring), 0);
    wait_clk(1);
    check_time("t4_trig", 0, 2, 0);
    check("t4_trig.ring", int'(ring), 1);
    wait_clk(239);
    check("t4_before_auto_clear.ring", int'(ring), 1);
    wait_clk(1);
    check("t4_auto_clear.ring", int'(ring), 0);
    check_time("t4_auto_clear", 0, 3, 0);

    // 5a: ring survives entering SET_HR, stop_pls silences it
    setup_alarm_0002();
    wait_clk(238);
    check("t5a_trig.ring", int'(ring), 1);
    pulse_mode(1);
    check("t5a_set_hr.mode", int'(mode), 1);
    check("t5a_set_hr.ring", int'(ring), 1);
    stop_pls = 1'b1;
    @(negedge clk);
    stop_pls = 1'b0;
    check("t5a_stop.ring", int'(ring), 0);

    // 5b: stop_pls coincident with the trigger tick
    setup_alarm_0002();
    wait_clk(237);
    stop_pls = 1'b1;
    @(negedge clk);
    stop_pls = 1'b0;
    check("t5b_stop_on_trig.ring", int'(ring), 0);
    check_time("t5b_stop_on_trig", 0, 2, 0);
    wait_clk(8);
    check("t5b_later.ring", int'(ring), 0);

    // 5c: alarm disarmed
    setup_alarm_0002();
    alm_en = 1'b0;
    wait_clk(238);
    check("t5c_disarmed.ring", int'(ring), 0);
    check_time("t5c_disarmed", 0, 2, 0);

    // 6: inc ignored in RUN, mode wins over inc, async reset mid-SET_MIN
    do_reset();
    pulse_inc(1);
    check("t6_run_inc.hours", int'(hours), 0);
    check("t6_run_inc.minutes", int'(minutes), 0);
    pulse_mode(1);
    mode_pls = 1'b1;
    inc_pls  = 1'b1;
    @(negedge clk);
    mode_pls = 1'b0;
    inc_pls  = 1'b0;
    check("t6_mode_wins.mode", int'(mode), 2);
    check("t6_mode_wins.hours", int'(hours), 0);
    pulse_inc(3);
    check("t6_set_min.minutes", int'(minutes), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("t6_async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    wait_clk(2);
    check("t6_after_release.mode", int'(mode), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
